// File: rtl/harris_pkg.sv
// Shared constants and helpers for the Harris corner-response pipeline.
// Optional threshold feature: HARRIS_THRESH_EN.
package harris_pkg;

  localparam int DEF_DATA_WIDTH = 23;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_K_NUM      = 25;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam logic [15:0] CNT_SAT = 16'hFFFF;

  function automatic int res_width(input int dw);
    return 2 * dw + 6;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == CNT_SAT) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/harris_if.sv
// Structure-tensor input streams and response output handshake.
// Optional threshold feature: HARRIS_THRESH_EN (ports live on the top).
interface harris_if
  import harris_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  localparam int RES_WIDTH = res_width(DATA_WIDTH);

  logic [DATA_WIDTH-2:0] in_xx_value;
  logic [ADDR_WIDTH-1:0] in_xx_addr;
  logic                  in_xx_valid;
  logic                  in_xx_ready;

  logic [DATA_WIDTH-1:0] in_xy_value;
  logic [ADDR_WIDTH-1:0] in_xy_addr;
  logic                  in_xy_valid;
  logic                  in_xy_ready;

  logic [DATA_WIDTH-2:0] in_yy_value;
  logic [ADDR_WIDTH-1:0] in_yy_addr;
  logic                  in_yy_valid;
  logic                  in_yy_ready;

  logic signed [RES_WIDTH-1:0] out_value;
  logic [ADDR_WIDTH-1:0]       out_addr;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output in_xx_value, in_xx_addr, in_xx_valid,
    input  in_xx_ready,
    output in_xy_value, in_xy_addr, in_xy_valid,
    input  in_xy_ready,
    output in_yy_value, in_yy_addr, in_yy_valid,
    input  in_yy_ready,
    input  out_value, out_addr, out_valid,
    output out_ready
  );

  modport slave (
    input  in_xx_value, in_xx_addr, in_xx_valid,
    output in_xx_ready,
    input  in_xy_value, in_xy_addr, in_xy_valid,
    output in_xy_ready,
    input  in_yy_value, in_yy_addr, in_yy_valid,
    output in_yy_ready,
    output out_value, out_addr, out_valid,
    input  out_ready
  );

endinterface

// File: rtl/harris_evt_fifo.sv
// First-word-fall-through event FIFO with full/empty/count.
// Used per input channel of the Harris pipeline (HARRIS_THRESH_EN agnostic).
module harris_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is a plain RAM; only the pointers need reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/harris_resp_pipe.sv
// Pipelined Harris response R = K*(xx*yy - xy^2) - (xx+yy)^2 with address join.
// Optional feature macro: HARRIS_THRESH_EN (threshold gate + supp_cnt).
module harris_resp_pipe
  import harris_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int K_NUM       = DEF_K_NUM,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  localparam int RES_WIDTH  = res_width(DATA_WIDTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  harris_if.slave     bus,
`ifdef HARRIS_THRESH_EN
  input  logic signed [RES_WIDTH-1:0] thresh,
  output logic [15:0] supp_cnt,
`endif
  output logic [15:0] mismatch_cnt
);

  localparam int UW  = DATA_WIDTH - 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int QW  = 2 * DATA_WIDTH;
  localparam int DW2 = 2 * DATA_WIDTH + 1;

  logic [UW-1:0]         xx_h, yy_h;
  logic [DATA_WIDTH-1:0] xy_h;
  logic [ADDR_WIDTH-1:0] xx_a, xy_a, yy_a, mn;
  logic xx_full, xy_full, yy_full;
  logic xx_empty, xy_empty, yy_empty;
  logic [CW-1:0] xx_cnt, xy_cnt, yy_cnt;
  logic pop_xx, pop_xy, pop_yy;
  logic adv, go, aligned;
  logic unused_cnt;

  harris_evt_fifo #(.WIDTH(ADDR_WIDTH+UW), .DEPTH(FIFO_DEPTH)) u_xx (
    .clk(clk), .rst_n(rst_n),
    .push(bus.in_xx_valid),
    .wdata({bus.in_xx_addr, bus.in_xx_value}),
    .pop(pop_xx), .rdata({xx_a, xx_h}),
    .full(xx_full), .empty(xx_empty), .count(xx_cnt)
  );

  harris_evt_fifo #(.WIDTH(ADDR_WIDTH+DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_xy (
    .clk(clk), .rst_n(rst_n),
    .push(bus.in_xy_valid),
    .wdata({bus.in_xy_addr, bus.in_xy_value}),
    .pop(pop_xy), .rdata({xy_a, xy_h}),
    .full(xy_full), .empty(xy_empty), .count(xy_cnt)
  );

  harris_evt_fifo #(.WIDTH(ADDR_WIDTH+UW), .DEPTH(FIFO_DEPTH)) u_yy (
    .clk(clk), .rst_n(rst_n),
    .push(bus.in_yy_valid),
    .wdata({bus.in_yy_addr, bus.in_yy_value}),
    .pop(pop_yy), .rdata({yy_a, yy_h}),
    .full(yy_full), .empty(yy_empty), .count(yy_cnt)
  );

  assign unused_cnt      = ^{xx_cnt, xy_cnt, yy_cnt};
  assign bus.in_xx_ready = !xx_full;
  assign bus.in_xy_ready = !xy_full;
  assign bus.in_yy_ready = !yy_full;

  logic                  out_valid_q;
  logic [RES_WIDTH-1:0]  out_value_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;

  assign adv     = !out_valid_q || bus.out_ready;
  assign go      = adv && !xx_empty && !xy_empty && !yy_empty;
  assign aligned = (xx_a == xy_a) && (xy_a == yy_a);

  // On misalignment only the lagging (lowest-address) heads are dropped.
  always_comb begin
    mn = xx_a;
    if (xy_a < mn) mn = xy_a;
    if (yy_a < mn) mn = yy_a;
  end

  assign pop_xx = go && (xx_a == mn);
  assign pop_xy = go && (xy_a == mn);
  assign pop_yy = go && (yy_a == mn);

  logic [2*UW-1:0]       p_n;
  logic [QW-1:0]         q_n, xy_e;
  logic [DATA_WIDTH-1:0] s_n;

  always_comb begin
    xy_e = {{DATA_WIDTH{xy_h[DATA_WIDTH-1]}}, xy_h};
    p_n  = {{UW{1'b0}}, xx_h} * {{UW{1'b0}}, yy_h};
    q_n  = xy_e * xy_e;
    s_n  = {1'b0, xx_h} + {1'b0, yy_h};
  end

  logic                  v1;
  logic [ADDR_WIDTH-1:0] a1;
  logic [2*UW-1:0]       p1;
  logic [QW-1:0]         q1;
  logic [DATA_WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1           <= 1'b0;
      a1           <= '0;
      p1           <= '0;
      q1           <= '0;
      s1           <= '0;
      mismatch_cnt <= '0;
    end else if (adv) begin
      v1 <= go && aligned;
      a1 <= xx_a;
      p1 <= p_n;
      q1 <= q_n;
      s1 <= s_n;
      if (go && !aligned) mismatch_cnt <= sat_inc(mismatch_cnt);
    end
  end

  logic [DW2-1:0] d_n;
  logic [QW-1:0]  t_n;

  always_comb begin
    d_n = {3'b000, p1} - {1'b0, q1};
    t_n = {{DATA_WIDTH{1'b0}}, s1} * {{DATA_WIDTH{1'b0}}, s1};
  end

  logic                  v2;
  logic [ADDR_WIDTH-1:0] a2;
  logic [DW2-1:0]        d2;
  logic [QW-1:0]         t2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      a2 <= '0;
      d2 <= '0;
      t2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      a2 <= a1;
      d2 <= d_n;
      t2 <= t_n;
    end
  end

  logic [RES_WIDTH-1:0] d_x, t_x, k_x, r_n;
  logic                 pass;

  always_comb begin
    d_x = {{(RES_WIDTH-DW2){d2[DW2-1]}}, d2};
    t_x = {{(RES_WIDTH-QW){1'b0}}, t2};
    k_x = RES_WIDTH'(K_NUM);
    r_n = k_x * d_x - t_x;
  end

`ifdef HARRIS_THRESH_EN
  assign pass = $signed(r_n) > thresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      supp_cnt <= '0;
    end else if (adv && v2 && !pass) begin
      supp_cnt <= sat_inc(supp_cnt);
    end
  end
`else
  assign pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_addr_q  <= '0;
    end else if (adv) begin
      out_valid_q <= v2 && pass;
      if (v2 && pass) begin
        out_value_q <= r_n;
        out_addr_q  <= a2;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_addr  = out_addr_q;

endmodule
